mdu: RTL and testbench
======================

Name: mdu

Overview:
- Parametrised multiply/divide unit holding the HI/LO register pair for the pipelined MIPS core.
- Sits in the EX stage beside the ALU.
- Accepts mult/multu/div/divu with configurable latency and mthi/mtlo single-cycle writes.
- Exposes `busy` so hazard control can stall mfhi/mflo and further MDU instructions; `cancel` squashes an in-flight op on exception/flush.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (≥ 2).
- MUL_CYCLES, 5, cycles `busy` stays high for mult/multu (≥ 1).
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu (≥ 1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  op request, sampled on rising edge.
- op  in  3  operation code (see package).
- a  in  WIDTH  operand rs.
- b  in  WIDTH  operand rt.
- cancel  in  1  squash in-flight op; HI/LO keep pre-op values.
- busy  out  1  op in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: hi=0, lo=0, busy=0, counter=0, staged result cleared. Reset overrides start and cancel in the same cycle. Reset mid-operation aborts the op with no write.
- Idle acceptance (busy=0, start=1, sampled at edge E):
  - MULT/MULTU/DIV/DIVU: latch a, b, op; busy=1 after E; counter=MUL_CYCLES or DIV_CYCLES.
  - MTHI: hi=a at E; busy stays 0.
  - MTLO: lo=a at E; busy stays 0.
  - Reserved codes: no effect.
- In flight:
  - Counter decrements each edge while busy.
  - At the edge where counter==1: hi/lo take the result and busy clears.
  - busy is therefore high for exactly N cycles (N = MUL_CYCLES or DIV_CYCLES); the result is visible in the first cycle busy=0.
  - The result may be computed at acceptance and staged internally; only visibility timing is specified.
- start while busy=1 is ignored entirely, including MTHI/MTLO. The hazard unit must stall instead.
- Back-to-back: start may be asserted in the same cycle busy is 0 after completion; it is accepted at that edge.
- cancel:
  - While busy=1: busy=0 at the next edge, counter=0, hi/lo unchanged.
  - With busy=0: no effect.
  - Same edge as a new start while idle: start wins.
  - Same edge as the completion edge: cancel wins, no write.
- Arithmetic:
  - MULT: signed WIDTH×WIDTH → 2·WIDTH product; hi=upper half, lo=lower half.
  - MULTU: same, unsigned.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (b=0): full latency runs, but hi/lo are NOT updated.
  - Signed overflow (a=most-negative, b=−1): lo=a, hi=0.
- Outputs hi/lo are registered, with no combinational path from inputs.

Decomposition:
- Shared package `mdu_pkg` holds the op encodings:
  - MDU_MULT=3'd0, MDU_MULTU=3'd1, MDU_DIV=3'd2, MDU_DIVU=3'd3, MDU_MTHI=3'd4, MDU_MTLO=3'd5.
  - 3'd6 and 3'd7 are reserved (no-op).
- The package also holds the default latency constants.
- One sub-module, `mdu_calc`:
  - Combinational.
  - Inputs: op, a, b.
  - Outputs: hi/lo result and a div-by-zero flag.
  - Keeps the arithmetic and edge cases separate from the counter/handshake FSM in `mdu`.

Test Plan:
- MULT a=32'hFFFF_FFFE (−2), b=3 → busy high exactly 5 cycles; then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA. Same operands with MULTU → hi=32'h0000_0002, lo=32'hFFFF_FFFA.
- DIV a=−7, b=2 → after 10 busy cycles lo=32'hFFFF_FFFD (−3), hi=32'hFFFF_FFFF (−1). DIVU a=7, b=2 → lo=3, hi=1.
- Edge cases:
  - MTHI a=32'h1234 then MTLO a=32'h5678 on consecutive cycles → hi=32'h1234, lo=32'h5678, busy never rises.
  - DIV with b=0 after the MTHI/MTLO above → hi/lo stay 32'h1234/32'h5678 after 10 cycles.
  - DIV a=32'h8000_0000, b=−1 → lo=32'h8000_0000, hi=0.
- Busy/cancel interaction:
  - MULT started, then start+MTLO asserted during busy → ignored; lo reflects only the product.
  - cancel asserted on cycle 3 of a MULT → busy drops next edge, hi/lo unchanged.
  - cancel asserted on the completion cycle → no write.
- Reset asserted mid-DIV → next cycle hi=lo=0, busy=0. A new MULT started on the first cycle busy=0 after an op completes is accepted (busy high again).

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op encodings, default latencies and FSM state type for the MDU
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam int MUL_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT = 10;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } mdu_state_t;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational multiply/divide datapath with divide edge cases
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_zero
);

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic                    is_signed;
    logic [2*WIDTH-1:0]      ext_a;
    logic [2*WIDTH-1:0]      ext_b;
    logic [2*WIDTH-1:0]      prod;
    logic                    b_zero;
    logic                    div_ovf;
    logic signed [WIDTH-1:0] s_a;
    logic signed [WIDTH-1:0] s_div;
    logic signed [WIDTH-1:0] s_quo;
    logic signed [WIDTH-1:0] s_rem;
    logic [WIDTH-1:0]        u_div;
    logic [WIDTH-1:0]        u_quo;
    logic [WIDTH-1:0]        u_rem;

    always_comb begin
        is_signed = (op == MDU_MULT) || (op == MDU_DIV);
        ext_a = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        ext_b = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        // Low 2*WIDTH bits of the extended product are correct for both signednesses.
        prod = ext_a * ext_b;

        b_zero  = (b == '0);
        div_ovf = (a == MOST_NEG) && (b == '1);
        // Substituting 1 keeps the dividers well-defined; overflow then yields q=a, r=0.
        s_a   = a;
        s_div = (b_zero || div_ovf) ? ONE : b;
        s_quo = s_a / s_div;
        s_rem = s_a % s_div;
        u_div = b_zero ? ONE : b;
        u_quo = a / u_div;
        u_rem = a % u_div;

        div_zero = is_div_op(op) && b_zero;
        res_hi   = '0;
        res_lo   = '0;
        case (op)
            MDU_MULT, MDU_MULTU: begin
                res_hi = prod[2*WIDTH-1:WIDTH];
                res_lo = prod[WIDTH-1:0];
            end
            MDU_DIV: begin
                res_hi = s_rem;
                res_lo = s_quo;
            end
            MDU_DIVU: begin
                res_hi = u_rem;
                res_lo = u_quo;
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - HI/LO multiply/divide unit with fixed-latency busy, cancel and mthi/mtlo
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT,
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    mdu_state_t       state;
    mdu_state_t       next_state;
    logic [CW-1:0]    count;
    logic [CW-1:0]    next_count;
    logic             load;
    logic             commit;
    logic             write_hi;
    logic             write_lo;

    logic [WIDTH-1:0] calc_hi;
    logic [WIDTH-1:0] calc_lo;
    logic             calc_dz;
    logic [WIDTH-1:0] staged_hi;
    logic [WIDTH-1:0] staged_lo;
    logic             staged_dz;

    mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .op       (op),
        .a        (a),
        .b        (b),
        .res_hi   (calc_hi),
        .res_lo   (calc_lo),
        .div_zero (calc_dz)
    );

    assign busy = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            hi        <= '0;
            lo        <= '0;
            staged_hi <= '0;
            staged_lo <= '0;
            staged_dz <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            if (load) begin
                staged_hi <= calc_hi;
                staged_lo <= calc_lo;
                staged_dz <= calc_dz;
            end
            if (commit) begin
                hi <= staged_hi;
                lo <= staged_lo;
            end
            if (write_hi) hi <= a;
            if (write_lo) lo <= a;
        end
    end

    always_comb begin
        next_state = state;
        next_count = count;
        load       = 1'b0;
        commit     = 1'b0;
        write_hi   = 1'b0;
        write_lo   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            next_state = ST_RUN;
                            next_count = CW'(MUL_CYCLES);
                            load       = 1'b1;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            next_state = ST_RUN;
                            next_count = CW'(DIV_CYCLES);
                            load       = 1'b1;
                        end
                        MDU_MTHI: write_hi = 1'b1;
                        MDU_MTLO: write_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // Cancel beats completion: a squashed op must never reach HI/LO.
                if (cancel) begin
                    next_state = ST_IDLE;
                    next_count = '0;
                end else if (count == CW'(1)) begin
                    next_state = ST_IDLE;
                    next_count = '0;
                    commit     = !staged_dz;
                end else begin
                    next_count = count - CW'(1);
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_count = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - scoreboard testbench for mdu
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;
    logic [63:0] sb_q[$];
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    mdu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            MDU_MULT:  begin q = sx * sy; return q; end
            MDU_MULTU: return ux * uy;
            MDU_DIV: begin
                if (y == 0) return {mhi, mlo};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            MDU_DIVU: begin
                if (y == 0) return {mhi, mlo};
                uq = ux / uy;
                ur = ux % uy;
                return {ur[31:0], uq[31:0]};
            end
            default: return {mhi, mlo};
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        if (o <= MDU_DIVU) sb_q.push_back(model(o, x, y));
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        tests++; if (hi !== 32'd0)  begin fails++; $display("FAIL reset_hi: got %h expected %h", hi, 32'd0); end
        tests++; if (lo !== 32'd0)  begin fails++; $display("FAIL reset_lo: got %h expected %h", lo, 32'd0); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        mhi = '0; mlo = '0;
        tick();
    endtask

    task automatic test_arith(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int n_exp);
        int n;
        logic [63:0] exp;
        issue(o, x, y);
        wait_idle(n);
        tests++; if (n !== n_exp) begin fails++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, n, n_exp); end
        exp = sb_q.pop_front();
        tests++; if (hi !== exp[63:32]) begin fails++; $display("FAIL %s_hi: got %h expected %h", name, hi, exp[63:32]); end
        tests++; if (lo !== exp[31:0])  begin fails++; $display("FAIL %s_lo: got %h expected %h", name, lo, exp[31:0]); end
        mhi = exp[63:32]; mlo = exp[31:0];
        tick();
    endtask

    task automatic test_mthi_mtlo();
        logic saw_busy;
        saw_busy = 1'b0;
        issue(MDU_MTHI, 32'h1234, 32'h0);
        saw_busy |= busy;
        issue(MDU_MTLO, 32'h5678, 32'h0);
        saw_busy |= busy;
        issue(3'd6, 32'hDEAD_BEEF, 32'h1);
        saw_busy |= busy;
        issue(3'd7, 32'hCAFE_F00D, 32'h1);
        saw_busy |= busy;
        tick();
        saw_busy |= busy;
        mhi = 32'h1234; mlo = 32'h5678;
        tests++; if (hi !== 32'h1234)  begin fails++; $display("FAIL mthi: got %h expected %h", hi, 32'h1234); end
        tests++; if (lo !== 32'h5678)  begin fails++; $display("FAIL mtlo: got %h expected %h", lo, 32'h5678); end
        tests++; if (saw_busy !== 1'b0) begin fails++; $display("FAIL mt_busy: got %b expected 0", saw_busy); end
    endtask

    task automatic test_start_while_busy();
        int n;
        logic [63:0] exp;
        issue(MDU_MULT, 32'd1000, 32'hFFFF_FFF9);
        tick();
        start = 1'b1; op = MDU_MTLO; a = 32'hDEAD_0000;
        tick();
        start = 1'b1; op = MDU_MTHI; a = 32'hBEEF_0000;
        tick();
        start = 1'b0;
        wait_idle(n);
        exp = sb_q.pop_front();
        tests++; if (n !== 2) begin fails++; $display("FAIL ignore_busy_cycles: got %0d expected %0d", n, 2); end
        tests++; if ({hi, lo} !== exp) begin fails++; $display("FAIL ignore_start: got %h expected %h", {hi, lo}, exp); end
        mhi = exp[63:32]; mlo = exp[31:0];
        tick();
    endtask

    task automatic test_cancel(input string name, input int delay);
        issue(MDU_MULT, 32'h0001_0000, 32'h0003_0000);
        void'(sb_q.pop_back());
        repeat (delay) tick();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL %s_busy_before: got %b expected 1", name, busy); end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy_after: got %b expected 0", name, busy); end
        tick(); tick();
        tests++; if ({hi, lo} !== {mhi, mlo}) begin fails++; $display("FAIL %s_hilo: got %h expected %h", name, {hi, lo}, {mhi, mlo}); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s_stays_idle: got %b expected 0", name, busy); end
    endtask

    task automatic test_reset_mid_div();
        issue(MDU_DIV, 32'd100, 32'd7);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_q.delete();
        mhi = '0; mlo = '0;
        tests++; if ({hi, lo} !== 64'd0) begin fails++; $display("FAIL reset_mid_hilo: got %h expected 0", {hi, lo}); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_mid_busy: got %b expected 0", busy); end
        repeat (12) tick();
        tests++; if ({hi, lo} !== 64'd0) begin fails++; $display("FAIL reset_mid_no_write: got %h expected 0", {hi, lo}); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [63:0] exp;
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        exp = sb_q.pop_front();
        tests++; if ({hi, lo} !== exp) begin fails++; $display("FAIL b2b_first: got %h expected %h", {hi, lo}, exp); end
        mhi = exp[63:32]; mlo = exp[31:0];
        issue(MDU_MULT, 32'h8000_0000, 32'h8000_0000);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: got %b expected 1", busy); end
        wait_idle(n);
        exp = sb_q.pop_front();
        tests++; if (n !== 5) begin fails++; $display("FAIL b2b_busy_cycles: got %0d expected %0d", n, 5); end
        tests++; if ({hi, lo} !== exp) begin fails++; $display("FAIL b2b_second: got %h expected %h", {hi, lo}, exp); end
        mhi = exp[63:32]; mlo = exp[31:0];
    endtask

    initial begin
        test_reset();
        test_arith("mult",  MDU_MULT,  32'hFFFF_FFFE, 32'd3, 5);
        tests++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin fails++; $display("FAIL mult_const: got %h expected %h", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA); end
        test_arith("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 5);
        tests++; if ({hi, lo} !== 64'h0000_0002_FFFF_FFFA) begin fails++; $display("FAIL multu_const: got %h expected %h", {hi, lo}, 64'h0000_0002_FFFF_FFFA); end
        test_arith("div",   MDU_DIV,   32'hFFFF_FFF9, 32'd2, 10);
        tests++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin fails++; $display("FAIL div_const: got %h expected %h", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD); end
        test_arith("divu",  MDU_DIVU,  32'd7, 32'd2, 10);
        tests++; if ({hi, lo} !== 64'h0000_0001_0000_0003) begin fails++; $display("FAIL divu_const: got %h expected %h", {hi, lo}, 64'h0000_0001_0000_0003); end
        test_arith("divu_big", MDU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        test_arith("div_negdiv", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 10);
        test_mthi_mtlo();
        test_arith("div_zero", MDU_DIV, 32'd55, 32'd0, 10);
        tests++; if ({hi, lo} !== 64'h0000_1234_0000_5678) begin fails++; $display("FAIL div_zero_const: got %h expected %h", {hi, lo}, 64'h0000_1234_0000_5678); end
        test_arith("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        tests++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin fails++; $display("FAIL div_ovf_const: got %h expected %h", {hi, lo}, 64'h0000_0000_8000_0000); end
        test_start_while_busy();
        test_cancel("cancel_mid", 2);
        test_cancel("cancel_done", 4);
        test_reset_mid_div();
        test_back_to_back();
        tests++; if (sb_q.size() !== 0) begin fails++; $display("FAIL scoreboard_empty: got %0d expected 0", sb_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
